// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong display path.
//   - Screen geometry (XSCREEN x YSCREEN) and the background colour BG.
//   - Client index constants for the pixel arbiter.
//   - Arbiter state enumeration.
//   - idx_wrap_add: modulo-NCLI addition used to walk the client ring.
package pong_pkg;

    localparam int NCLI    = 3;
    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int WD_W    = 23;

    localparam logic [2:0] BG = 3'b000;

    localparam logic [1:0] CLI_PADDLE_L = 2'd0;
    localparam logic [1:0] CLI_PADDLE_R = 2'd1;
    localparam logic [1:0] CLI_BALL     = 2'd2;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        GRANT  = 2'd2,
        SWITCH = 2'd3
    } state_t;

    // (idx + step) mod NCLI for idx < NCLI and step <= NCLI.
    function automatic logic [1:0] idx_wrap_add(input logic [1:0] idx,
                                                input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, idx} + {1'b0, step};
        if (sum >= 3'(NCLI)) begin
            sum = sum - 3'(NCLI);
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/rr_next.sv
// rr_next: combinational round-robin successor search.
//   cur_i   : current client index
//   mask_i  : participating clients (1 = in)
//   next_o  : first set mask index after cur_i, wrapping; cur_i itself is
//             the last candidate so a lone client is re-selected
//   valid_o : 1 when any mask bit is set
module rr_next
    import pong_pkg::*;
(
    input  logic [1:0]      cur_i,
    input  logic [NCLI-1:0] mask_i,
    output logic [1:0]      next_o,
    output logic            valid_o
);

    logic [1:0]      cand [NCLI];
    logic [NCLI-1:0] hit;

    // cand[k] is the client k+1 places after cur_i on the ring.
    genvar gi;
    generate
        for (gi = 0; gi < NCLI; gi++) begin : g_cand
            assign cand[gi] = idx_wrap_add(cur_i, 2'(gi + 1));
            assign hit[gi]  = mask_i[cand[gi]];
        end
    endgenerate

    // Nearest candidate wins: scan from farthest to nearest, last hit sticks.
    always_comb begin
        next_o  = cur_i;
        valid_o = 1'b0;
        for (int i = NCLI - 1; i >= 0; i--) begin
            if (hit[i]) begin
                next_o  = cand[i];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_arbiter.sv
// pixel_arbiter: owns the single VGA adapter write port and grants it
// round-robin to three drawing clients (two paddles, ball).
//
// Ports:
//   CLOCK_50, Resetn      clock, synchronous active-low reset
//   cli_x/y/color/plot    packed per-client pixel streams (client i in slice i)
//   cli_done              per-client end-of-draw pulse
//   cli_mask              per-client participation
//   enable                one-hot grant (zero outside GRANT)
//   VGA_X/Y/COLOR, plot   adapter write port
//   grant_id              current or most recent grantee
//   timeout_flag          sticky watchdog-expiry flag
//
// Build option: define PIXEL_ARBITER_CLEAR_EN to include the power-up sweep
// that paints the whole screen with BG before arbitration starts.
module pixel_arbiter
    import pong_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32'd4194304
) (
    input  logic                CLOCK_50,
    input  logic                Resetn,
    input  logic [8*NCLI-1:0]   cli_x,
    input  logic [7*NCLI-1:0]   cli_y,
    input  logic [3*NCLI-1:0]   cli_color,
    input  logic [NCLI-1:0]     cli_plot,
    input  logic [NCLI-1:0]     cli_done,
    input  logic [NCLI-1:0]     cli_mask,
    output logic [NCLI-1:0]     enable,
    output logic [7:0]          VGA_X,
    output logic [6:0]          VGA_Y,
    output logic [2:0]          VGA_COLOR,
    output logic                plot,
    output logic [1:0]          grant_id,
    output logic                timeout_flag
);

`ifdef PIXEL_ARBITER_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [7:0] clr_x_q;
    logic [6:0] clr_y_q;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t          state_q;
    logic [1:0]      grant_id_q;
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    logic [1:0]      rr_cur_d;
    logic [1:0]      rr_next_idx;
    logic            rr_valid;
    logic            wd_expired;

    logic [7:0]      px_x     [NCLI];
    logic [6:0]      px_y     [NCLI];
    logic [2:0]      px_color [NCLI];

    genvar gi;
    generate
        for (gi = 0; gi < NCLI; gi++) begin : g_unpack
            assign px_x[gi]     = cli_x[8*gi +: 8];
            assign px_y[gi]     = cli_y[7*gi +: 7];
            assign px_color[gi] = cli_color[3*gi +: 3];
        end
    endgenerate

    // Searching "after the last client" from IDLE yields the lowest set index.
    assign rr_cur_d = (state_q == IDLE) ? CLI_BALL : grant_id_q;

    rr_next u_rr_next (
        .cur_i   (rr_cur_d),
        .mask_i  (cli_mask),
        .next_o  (rr_next_idx),
        .valid_o (rr_valid)
    );

    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q    <= RST_STATE;
            grant_id_q <= CLI_PADDLE_L;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`ifdef PIXEL_ARBITER_CLEAR_EN
            clr_x_q    <= '0;
            clr_y_q    <= '0;
`endif
        end else begin
            case (state_q)
`ifdef PIXEL_ARBITER_CLEAR_EN
                CLEAR: begin
                    if (clr_x_q == 8'(XSCREEN - 1)) begin
                        clr_x_q <= '0;
                        if (clr_y_q == 7'(YSCREEN - 1)) begin
                            clr_y_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            clr_y_q <= clr_y_q + 7'd1;
                        end
                    end else begin
                        clr_x_q <= clr_x_q + 8'd1;
                    end
                end
`endif
                IDLE: begin
                    if (rr_valid) begin
                        grant_id_q <= rr_next_idx;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    wd_q <= wd_q + 1'b1;
                    // done has priority: a coincident expiry is not a timeout
                    if (cli_done[grant_id_q]) begin
                        state_q <= SWITCH;
                    end else if (wd_expired) begin
                        state_q   <= SWITCH;
                        timeout_q <= 1'b1;
                    end
                end
                SWITCH: begin
                    wd_q <= '0;
                    if (rr_valid) begin
                        grant_id_q <= rr_next_idx;
                        state_q    <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= RST_STATE;
            endcase
        end
    end

    always_comb begin
        enable    = '0;
        VGA_X     = '0;
        VGA_Y     = '0;
        VGA_COLOR = BG;
        plot      = 1'b0;
        case (state_q)
`ifdef PIXEL_ARBITER_CLEAR_EN
            CLEAR: begin
                VGA_X = clr_x_q;
                VGA_Y = clr_y_q;
                plot  = 1'b1;
            end
`endif
            GRANT: begin
                enable[grant_id_q] = 1'b1;
                VGA_X              = px_x[grant_id_q];
                VGA_Y              = px_y[grant_id_q];
                VGA_COLOR          = px_color[grant_id_q];
                plot               = cli_plot[grant_id_q];
            end
            default: ;
        endcase
        // Adapter must see no writes while reset is held, even before the edge.
        if (!Resetn) begin
            enable = '0;
            plot   = 1'b0;
        end
    end

    assign grant_id     = grant_id_q;
    assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_pixel_arbiter.sv
module tb_pixel_arbiter;

    localparam int TO     = 16;
    localparam int NTRANS = 60;

    logic        CLOCK_50 = 1'b0;
    logic        Resetn;
    logic [23:0] cli_x;
    logic [20:0] cli_y;
    logic [8:0]  cli_color;
    logic [2:0]  cli_plot;
    logic [2:0]  cli_done;
    logic [2:0]  cli_mask;
    logic [2:0]  enable;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [2:0]  VGA_COLOR;
    logic        plot;
    logic [1:0]  grant_id;
    logic        timeout_flag;

    always #10 CLOCK_50 = ~CLOCK_50;

    pixel_arbiter #(.TIMEOUT(TO)) dut (
        .CLOCK_50     (CLOCK_50),
        .Resetn       (Resetn),
        .cli_x        (cli_x),
        .cli_y        (cli_y),
        .cli_color    (cli_color),
        .cli_plot     (cli_plot),
        .cli_done     (cli_done),
        .cli_mask     (cli_mask),
        .enable       (enable),
        .VGA_X        (VGA_X),
        .VGA_Y        (VGA_Y),
        .VGA_COLOR    (VGA_COLOR),
        .plot         (plot),
        .grant_id     (grant_id),
        .timeout_flag (timeout_flag)
    );

    typedef struct {
        int id;
        int dur;
        int tflag;
        bit chk_gap;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Round-robin rule: first participating client after prev, wrapping.
    function automatic int rr_after(input int prev, input logic [2:0] m);
        for (int k = 1; k <= 3; k++) begin
            if (m[(prev + k) % 3]) return (prev + k) % 3;
        end
        return -1;
    endfunction

    function automatic int lowest(input logic [2:0] m);
        for (int i = 0; i < 3; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_pixels();
        cli_x     = 24'($urandom);
        cli_y     = 21'($urandom);
        cli_color = 9'($urandom);
        cli_plot  = 3'($urandom);
    endtask

    task automatic wait_grant(input string name);
        int w;
        w = 0;
        while (enable == 3'b000) begin
            if (w == 10) begin
                check(name, 0, 1);
                finish_run();
            end
            @(posedge CLOCK_50);
            #1;
            w++;
        end
    endtask

    // Monitor: one scoreboard entry per grant window (enable nonzero).
    initial begin
        exp_t cur;
        bit   in_grant;
        int   dur;
        int   gap;
        in_grant = 1'b0;
        dur      = 0;
        gap      = 0;
        cur.id = 0; cur.dur = 0; cur.tflag = 0; cur.chk_gap = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (mon_on) begin
                if (enable != 3'b000) begin
                    if (!in_grant) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_grant", 32'(enable), 0);
                        end else begin
                            cur      = sb_q[0];
                            in_grant = 1'b1;
                            dur      = 0;
                            if (cur.chk_gap) check("grant_gap", gap, 1);
                        end
                    end
                    if (in_grant) begin
                        check("enable_onehot", 32'(enable), 1 << cur.id);
                        check("grant_id", 32'(grant_id), cur.id);
                        check("vga_x", 32'(VGA_X), 32'(cli_x[8*cur.id +: 8]));
                        check("vga_y", 32'(VGA_Y), 32'(cli_y[7*cur.id +: 7]));
                        check("vga_color", 32'(VGA_COLOR), 32'(cli_color[3*cur.id +: 3]));
                        check("vga_plot", 32'(plot), 32'(cli_plot[cur.id]));
                        dur++;
                    end
                end else begin
                    check("idle_plot", 32'(plot), 0);
                    if (in_grant) begin
                        check("grant_len", dur, cur.dur);
                        check("timeout_flag", 32'(timeout_flag), cur.tflag);
                        $display("grant client=%0d cycles=%0d timeout_flag=%0d",
                                 cur.id, dur, timeout_flag);
                        void'(sb_q.pop_front());
                        in_grant = 1'b0;
                        gap      = 0;
                    end
                    gap++;
                end
            end
        end
    end

    initial begin
        #2000000;
        checks++;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        finish_run();
    end

    // Stimulus and reference model.
    initial begin
        exp_t        e;
        int          tflag_m;
        int          exp_id;
        int          prev;
        int          len;
        int          mid;
        int          c;
        bit          gapflag;
        logic [2:0]  newmask;
        logic [2:0]  dn;

        Resetn    = 1'b0;
        cli_x     = '0;
        cli_y     = '0;
        cli_color = '0;
        cli_plot  = '0;
        cli_done  = '0;
        cli_mask  = '0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset_enable", 32'(enable), 0);
        check("reset_plot", 32'(plot), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_timeout_flag", 32'(timeout_flag), 0);
        @(posedge CLOCK_50);
        #1;
        Resetn = 1'b1;

`ifdef PIXEL_ARBITER_CLEAR_EN
        begin : sweep
            int n;
            int lx;
            int ly;
            int lc;
            int en_seen;
            n = 0; lx = -1; ly = -1; lc = -1; en_seen = 0;
            @(negedge CLOCK_50);
            check("sweep_first_x", 32'(VGA_X), 0);
            check("sweep_first_y", 32'(VGA_Y), 0);
            while (plot == 1'b1 && n < 20000) begin
                lx = 32'(VGA_X);
                ly = 32'(VGA_Y);
                lc = 32'(VGA_COLOR);
                if (enable != 3'b000) en_seen = 1;
                n++;
                @(negedge CLOCK_50);
            end
            check("sweep_len", n, 19200);
            check("sweep_last_x", lx, 159);
            check("sweep_last_y", ly, 119);
            check("sweep_color", lc, 0);
            check("sweep_enable", en_seen, 0);
            $display("sweep pixels=%0d last=(%0d,%0d)", n, lx, ly);
        end
`endif

        mon_on   = 1'b1;
        tflag_m  = 0;
        cli_mask = 3'($urandom_range(7, 1));
        exp_id   = lowest(cli_mask);
        gapflag  = 1'b0;

        for (int t = 0; t < NTRANS; t++) begin
            len     = (t == 0) ? 20 : int'($urandom_range(20, 1));
            newmask = (t == NTRANS - 1) ? 3'b000 : 3'($urandom_range(7, 0));
            if (len > TO) tflag_m = 1;
            e.id      = exp_id;
            e.dur     = (len > TO) ? TO : len;
            e.tflag   = tflag_m;
            e.chk_gap = gapflag;
            sb_q.push_back(e);

            cli_done = '0;
            wait_grant("grant_wait");

            c   = 1;
            mid = int'($urandom_range((len > TO) ? TO : len, 1));
            forever begin
                // Done pulses from other clients are noise the arbiter must ignore.
                dn = 3'($urandom) & ~(3'b001 << exp_id);
                if (c == len) dn[exp_id] = 1'b1;
                cli_done = dn;
                if (c == mid) cli_mask = newmask;
                drive_pixels();
                @(posedge CLOCK_50);
                #1;
                cli_done = '0;
                if (enable == 3'b000) break;
                c++;
                if (c > TO + 4) begin
                    check("grant_end", 0, 1);
                    finish_run();
                end
            end

            prev = exp_id;
            if (newmask != 3'b000) begin
                exp_id  = rr_after(prev, newmask);
                gapflag = 1'b1;
            end else begin
                repeat ($urandom_range(4, 1)) begin
                    drive_pixels();
                    @(posedge CLOCK_50);
                    #1;
                end
                if (t < NTRANS - 1) begin
                    cli_mask = 3'($urandom_range(7, 1));
                    exp_id   = lowest(cli_mask);
                    gapflag  = 1'b0;
                end
            end
        end

        repeat (3) @(posedge CLOCK_50);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        // Directed pass-through on client 2, then reset while it holds the grant.
        mon_on    = 1'b0;
        cli_x     = {8'd80, 8'd11, 8'd22};
        cli_y     = {7'd60, 7'd33, 7'd44};
        cli_color = {3'b111, 3'b010, 3'b001};
        cli_plot  = 3'b100;
        cli_mask  = 3'b100;
        wait_grant("directed_grant_wait");
        @(negedge CLOCK_50);
        check("pt_enable", 32'(enable), 4);
        check("pt_grant_id", 32'(grant_id), 2);
        check("pt_vga_x", 32'(VGA_X), 80);
        check("pt_vga_y", 32'(VGA_Y), 60);
        check("pt_vga_color", 32'(VGA_COLOR), 7);
        check("pt_plot", 32'(plot), 1);
        check("pt_timeout_sticky", 32'(timeout_flag), tflag_m);
        @(posedge CLOCK_50);
        #1;
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        check("rst_same_cycle_enable", 32'(enable), 0);
        check("rst_same_cycle_plot", 32'(plot), 0);
        @(posedge CLOCK_50);
        #1;
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_timeout_flag", 32'(timeout_flag), 0);
        $display("mid-grant reset grant_id=%0d timeout_flag=%0d", grant_id, timeout_flag);
        Resetn = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        finish_run();
    end

endmodule

// File: doc/pixel_arbiter.md
# pixel_arbiter

Downstream pixel arbiter for the pong display path. It owns the single VGA adapter write port and grants it to one of three drawing objects at a time (two paddles and the ball) using a round-robin `enable`. While a client holds the grant, the block forwards that client's `VGA_X`, `VGA_Y`, `VGA_COLOR` and `plot` to the adapter. On power-up it optionally sweeps the screen to the background colour.

## Interface
- `NCLI`, 3: number of clients. Fixed at 3; `grant_id` is 2 bits.
- `XSCREEN`, 160: screen width in pixels.
- `YSCREEN`, 120: screen height in pixels.
- `BG`, 3'b000: background colour used by the clear sweep.
- `TIMEOUT`, 2^22: watchdog length in cycles per grant. Counter width is 23 bits.

- `CLOCK_50`  in  1  system clock.
- `Resetn`  in  1  synchronous, active-low reset.
- `cli_x`  in  24  client X coordinates, 8 bits per client, client i at `[8i+7:8i]`.
- `cli_y`  in  21  client Y coordinates, 7 bits per client.
- `cli_color`  in  9  client colours, 3 bits per client.
- `cli_plot`  in  3  per-client pixel write strobe.
- `cli_done`  in  3  per-client end-of-draw pulse, driven by each client's `row` output.
- `cli_mask`  in  3  1 = client participates in arbitration.
- `enable`  out  3  one-hot grant; all zero when no client holds the grant.
- `VGA_X`  out  8  X coordinate to the adapter.
- `VGA_Y`  out  7  Y coordinate to the adapter.
- `VGA_COLOR`  out  3  colour to the adapter.
- `plot`  out  1  pixel write strobe to the adapter.
- `grant_id`  out  2  index of the current or most recent grantee.
- `timeout_flag`  out  1  sticky; set when the watchdog expires.

## Operation
- State machine states: CLEAR, IDLE, GRANT, SWITCH.
- Reset values:
  - state = CLEAR, or IDLE when the macro is off.
  - `grant_id` = 0.
  - clear counters = 0.
  - watchdog = 0.
  - `timeout_flag` = 0.
- While `Resetn`=0, `enable`=0 and `plot`=0, both combinationally forced.
- **CLEAR**:
  - Drives `VGA_X`/`VGA_Y` from the clear counters, `VGA_COLOR`=`BG`, `plot`=1, `enable`=0.
  - X increments each cycle from 0 to `XSCREEN`-1, then wraps to 0 and Y increments.
  - After pixel (159,119) the state moves to IDLE. The sweep takes 19200 cycles.
- **IDLE**:
  - `enable`=0, `plot`=0.
  - If any `cli_mask` bit is set, grant the lowest set index and go to GRANT.
- **GRANT**:
  - `enable[grant_id]`=1.
  - Outputs are combinationally muxed from client `grant_id`.
  - `plot` = `cli_plot[grant_id]`.
  - Watchdog increments each cycle.
  - Go to SWITCH on `cli_done[grant_id]` or when the watchdog reaches `TIMEOUT`-1. A timeout also sets `timeout_flag`.
- **SWITCH**:
  - Lasts one cycle, with `enable`=0 and `plot`=0. Watchdog is cleared.
  - The next grantee is the first masked-in index after `grant_id`, wrapping 2 to 0.
  - If the current client is the only one masked in, it is re-granted.
  - If the mask is empty, go to IDLE; otherwise go to GRANT.
- Mask changes:
  - A mask change during GRANT does not revoke the current grant; it takes effect at the next SWITCH.
  - `cli_done` from a non-granted client is ignored.
- Simultaneous `cli_done` and watchdog expiry: treated as done. `timeout_flag` is not set.
- `timeout_flag` is cleared only by reset.

## Timing
- Pixel path is zero-latency from client to adapter in GRANT, i.e. combinational.
- `enable` is decoded from the registered state and `grant_id`, so it changes one cycle after the deciding edge.
- Minimum gap between consecutive grants is 1 cycle (SWITCH).
- `cli_done` sampled on cycle N gives `enable` low on cycle N+1 and the new grantee's `enable` high on cycle N+2.
- Reset asserted mid-sweep or mid-grant: next edge goes to the reset state and the sweep restarts from (0,0).

## Configuration
- `PIXEL_ARBITER_CLEAR_EN`
  - Defined: the CLEAR state and its counters exist, and reset enters CLEAR.
  - Undefined: CLEAR is compiled out and reset enters IDLE directly. First grant goes to client 0 if `cli_mask[0]`=1.

## Structure
- Shared package `pong_pkg` holds:
  - `XSCREEN`, `YSCREEN`, `BG`.
  - The state enumeration.
  - Client index constants: `CLI_PADDLE_L`=0, `CLI_PADDLE_R`=1, `CLI_BALL`=2.
- One sub-module, `rr_next`: combinational next-index finder taking the current index and mask, returning the next index and a valid bit.

## Test plan
- **Clear sweep** (macro on): release reset → `plot`=1 for exactly 19200 cycles, the last pixel is (159,119) with colour `BG`, then IDLE.
- **Rotation**: mask=111, each client pulses done 50 cycles after grant → `grant_id` sequence 0,1,2,0 with exactly one `enable`=0 cycle between grants.
- **Skip masked client**: mask=101 → grants alternate 0,2,0; `enable[1]` is never high.
- **Watchdog**: client 1 never asserts done, `TIMEOUT` overridden to 16 → grant drops after 16 cycles, `timeout_flag`=1 and stays 1.
- **Pass-through**: client 2 granted with x=80, y=60, colour=3'b111, plot=1 → same-cycle `VGA_X`=80, `VGA_Y`=60, `VGA_COLOR`=111, `plot`=1.
- **Mid-grant reset**: `Resetn`=0 while client 2 is granted → `enable`=0 the same cycle, `grant_id`=0 and `timeout_flag`=0 after the edge.
